// File: rtl/imm_encoder.sv
// imm_encoder -- RISC-V instruction packer for the boot/test-program loader.
// Takes decoded fields plus a full 32-bit immediate and builds the 32-bit
// instruction word. This is the inverse of the core's immediate generator.
// Every immediate is range- and alignment-checked. An illegal request is
// still consumed, but it is flagged on err/err_count and never emitted.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request handshake (in_ready = !out_valid || out_ready)
//   in_fmt            0 R, 1 I, 2 I-shamt, 3 S, 4 B, 5 U, 6 J, 7 CSR-imm
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_csr, in_imm
//   out_valid/out_ready, out_inst, out_seq   emitted word and its index
//   err               one-cycle pulse after a rejected request
//   err_count         saturating count of rejected requests
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | output register holds no word, out_valid = 0
// S_FULL  | output register holds a word, out_valid = 1
module imm_encoder #(
  parameter int SEQ_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [11:0]      in_csr,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [SEQ_W-1:0] out_seq,
  output logic             err,
  output logic [7:0]       err_count
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_inst;
  logic [SEQ_W-1:0] r_seq;
  logic             r_err;
  logic [7:0]       r_err_count;

  logic [31:0]      w_inst;
  logic             w_legal;
  logic             w_accept;
  logic             w_hs;
  logic             w_load;

  assign out_valid = (r_state == S_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_hs      = out_valid && out_ready;
  assign w_load    = w_accept && w_legal;

  assign out_inst  = r_inst;
  assign out_seq   = r_seq;
  assign err       = r_err;
  assign err_count = r_err_count;

  always_comb begin
    w_inst = '0;
    case (in_fmt)
      3'd1: w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      3'd2: w_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
      3'd3: w_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      3'd4: w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_opcode};
      3'd5: w_inst = {in_imm[31:12], in_rd, in_opcode};
      3'd6: w_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      3'd7: w_inst = {in_csr, in_imm[4:0], in_funct3, in_rd, in_opcode};
      default: w_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    endcase
  end

  // A signed range -2^k..2^k-1 fits exactly when every bit from k upward
  // equals the sign bit, i.e. the upper slice is all zeros or all ones.
  always_comb begin
    w_legal = 1'b1;
    case (in_fmt)
      3'd1, 3'd3: w_legal = (&in_imm[31:11]) || !(|in_imm[31:11]);
      3'd2, 3'd7: w_legal = !(|in_imm[31:5]);
      3'd4:       w_legal = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
      3'd5:       w_legal = !(|in_imm[11:0]);
      3'd6:       w_legal = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
      default:    w_legal = 1'b1;
    endcase
  end

  // An illegal accept in S_FULL can only happen with out_ready high, so the
  // handshake branch drains the register in that case.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_load) w_state_nxt = S_FULL;
      S_FULL: begin
        if (w_load)    w_state_nxt = S_FULL;
        else if (w_hs) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_inst      <= '0;
      r_seq       <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_inst <= w_inst;
      if (w_hs)   r_seq  <= r_seq + SEQ_W'(1);
      r_err <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [11:0] in_csr;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [15:0] out_seq;
  logic        err;
  logic [7:0]  err_count;

  logic        o4_in_ready, o4_out_valid, o4_err;
  logic [31:0] o4_out_inst;
  logic [3:0]  o4_out_seq;
  logic [7:0]  o4_err_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_csr(in_csr), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_seq(out_seq),
    .err(err), .err_count(err_count)
  );

  imm_encoder #(.SEQ_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o4_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_csr(in_csr), .in_imm(in_imm), .out_valid(o4_out_valid),
    .out_ready(out_ready), .out_inst(o4_out_inst), .out_seq(o4_out_seq),
    .err(o4_err), .err_count(o4_err_count)
  );

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] csr;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [11:0] csr,
                         input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_csr = csr; in_imm = imm;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_inst !== 32'h0) $display("FAIL reset_out_inst got %h want 0", out_inst); else n_pass++;
    n_checks++; if (out_seq !== 16'd0) $display("FAIL reset_out_seq got %0d want 0", out_seq); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %0b want 0", err); else n_pass++;
    n_checks++; if (err_count !== 8'd0) $display("FAIL reset_err_count got %0d want 0", err_count); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_itype();
    apply_reset();
    out_ready = 1'b0;
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %0b want 1", out_valid); else n_pass++;
    n_checks++; if (out_inst !== 32'hFFF00093) $display("FAIL addi_inst got %h want fff00093", out_inst); else n_pass++;
    n_checks++; if (out_seq !== 16'd0) $display("FAIL addi_seq got %0d want 0", out_seq); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL addi_err got %0b want 0", err); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL addi_drain got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_seq !== 16'd1) $display("FAIL addi_seq_inc got %0d want 1", out_seq); else n_pass++;
  endtask

  task automatic test_s_shamt();
    apply_reset();
    set_req(3'd3, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 12'd0, 32'd4);
    in_valid = 1'b1;
    tick();
    set_req(3'd2, 7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 12'd0, 32'd7);
    n_checks++; if (out_inst !== 32'h0020A223) $display("FAIL sw_inst got %h want 0020a223", out_inst); else n_pass++;
    n_checks++; if (out_seq !== 16'd0) $display("FAIL sw_seq got %0d want 0", out_seq); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_inst !== 32'h40725193) $display("FAIL srai_inst got %h want 40725193", out_inst); else n_pass++;
    n_checks++; if (out_seq !== 16'd1) $display("FAIL srai_seq got %0d want 1", out_seq); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL srai_valid got %0b want 1", out_valid); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL srai_drain got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3];
    exp[0] = 32'hFE000EE3; exp[1] = 32'h001000EF; exp[2] = 32'h123452B7;
    apply_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_req(3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'hFFFF_FFFC);
        1: set_req(3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'h0000_0800);
        default: set_req(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'h1234_5000);
      endcase
      n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got %0b want 1", i, in_ready); else n_pass++;
      tick();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %0b want 1", i, out_valid); else n_pass++;
      n_checks++; if (out_inst !== exp[i]) $display("FAIL b2b_inst[%0d] got %h want %h", i, out_inst, exp[i]); else n_pass++;
      n_checks++; if (out_seq !== 16'(i)) $display("FAIL b2b_seq[%0d] got %0d want %0d", i, out_seq, i); else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_seq !== 16'd3) $display("FAIL b2b_seq_end got %0d want 3", out_seq); else n_pass++;
  endtask

  task automatic test_illegal();
    apply_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_req(3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd3);
        1: set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd2048);
        default: set_req(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'h0000_1001);
      endcase
      tick();
      n_checks++; if (err !== 1'b1) $display("FAIL illegal_err[%0d] got %0b want 1", i, err); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL illegal_valid[%0d] got %0b want 0", i, out_valid); else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (err !== 1'b0) $display("FAIL illegal_err_clear got %0b want 0", err); else n_pass++;
    n_checks++; if (err_count !== 8'd3) $display("FAIL illegal_count got %0d want 3", err_count); else n_pass++;
    n_checks++; if (out_inst !== 32'h0) $display("FAIL illegal_inst got %h want 0", out_inst); else n_pass++;
    // legal word, then an illegal accept while FULL with out_ready high drains it
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    tick();
    set_req(3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd3);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL illegal_full_drain got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL illegal_full_err got %0b want 1", err); else n_pass++;
    n_checks++; if (out_inst !== 32'hFFF00093) $display("FAIL illegal_full_inst got %h want fff00093", out_inst); else n_pass++;
    n_checks++; if (out_seq !== 16'd1) $display("FAIL illegal_full_seq got %0d want 1", out_seq); else n_pass++;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    tick();
    n_checks++; if (err_count !== 8'd255) $display("FAIL illegal_saturate got %0d want 255", err_count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL illegal_sat_valid got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_boundary();
    vec_t tbl [19];
    tbl[0]  = '{3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h0000_07FF, 1'b1, 32'h7FF00013};
    tbl[1]  = '{3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'hFFFF_F800, 1'b1, 32'h80000013};
    tbl[2]  = '{3'd3, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'hFFFF_F800, 1'b1, 32'h80000023};
    tbl[3]  = '{3'd3, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h0000_0800, 1'b0, 32'h0};
    tbl[4]  = '{3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'hFFFF_F000, 1'b1, 32'h80000063};
    tbl[5]  = '{3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h0000_0FFE, 1'b1, 32'h7E000FE3};
    tbl[6]  = '{3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h0000_1000, 1'b0, 32'h0};
    tbl[7]  = '{3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'hFFFF_EFFE, 1'b0, 32'h0};
    tbl[8]  = '{3'd2, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h0000_001F, 1'b1, 32'h01F00013};
    tbl[9]  = '{3'd2, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h0000_0020, 1'b0, 32'h0};
    tbl[10] = '{3'd6, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'hFFF0_0000, 1'b1, 32'h8000006F};
    tbl[11] = '{3'd6, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h0000_0002, 1'b1, 32'h0020006F};
    tbl[12] = '{3'd6, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h0010_0000, 1'b0, 32'h0};
    tbl[13] = '{3'd6, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h0000_0001, 1'b0, 32'h0};
    tbl[14] = '{3'd7, 7'h73, 5'd1, 5'd0, 5'd0, 3'd5, 7'h00, 12'h300, 32'h0000_001F, 1'b1, 32'h300FD0F3};
    tbl[15] = '{3'd7, 7'h73, 5'd1, 5'd0, 5'd0, 3'd5, 7'h00, 12'h300, 32'h0000_0020, 1'b0, 32'h0};
    tbl[16] = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 12'h000, 32'hDEAD_BEEF, 1'b1, 32'h402081B3};
    tbl[17] = '{3'd5, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'hFFFF_F000, 1'b1, 32'hFFFFF037};
    tbl[18] = '{3'd5, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'hFFFF_F001, 1'b0, 32'h0};
    apply_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      set_req(tbl[i].fmt, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
              tbl[i].f3, tbl[i].f7, tbl[i].csr, tbl[i].imm);
      tick();
      n_checks++; if (out_valid !== tbl[i].legal) $display("FAIL bound_valid[%0d] got %0b want %0b", i, out_valid, tbl[i].legal); else n_pass++;
      n_checks++; if (err !== !tbl[i].legal) $display("FAIL bound_err[%0d] got %0b want %0b", i, err, !tbl[i].legal); else n_pass++;
      if (tbl[i].legal) begin
        n_checks++; if (out_inst !== tbl[i].exp) $display("FAIL bound_inst[%0d] got %h want %h", i, out_inst, tbl[i].exp); else n_pass++;
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (err_count !== 8'd8) $display("FAIL bound_err_count got %0d want 8", err_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    tick();
    set_req(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'h1234_5000);
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); else n_pass++;
      n_checks++; if (out_inst !== 32'hFFF00093) $display("FAIL bp_inst[%0d] got %h want fff00093", i, out_inst); else n_pass++;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %0b want 1", i, out_valid); else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_inst !== 32'h123452B7) $display("FAIL bp_new_inst got %h want 123452b7", out_inst); else n_pass++;
    n_checks++; if (out_seq !== 16'd1) $display("FAIL bp_new_seq got %0d want 1", out_seq); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_new_valid got %0b want 1", out_valid); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req(3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd3);
    in_valid = 1'b1;
    tick();
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'hFFFF_FFFF);
    tick();
    tick();
    n_checks++; if (out_seq !== 16'd1) $display("FAIL rstmid_pre_seq got %0d want 1", out_seq); else n_pass++;
    n_checks++; if (err_count !== 8'd1) $display("FAIL rstmid_pre_count got %0d want 1", err_count); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_seq !== 16'd0) $display("FAIL rstmid_seq got %0d want 0", out_seq); else n_pass++;
    n_checks++; if (err_count !== 8'd0) $display("FAIL rstmid_count got %0d want 0", err_count); else n_pass++;
    n_checks++; if (out_inst !== 32'h0) $display("FAIL rstmid_inst got %h want 0", out_inst); else n_pass++;
  endtask

  task automatic test_seq_wrap();
    apply_reset();
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd5);
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      n_checks++; if (o4_out_seq !== 4'(i % 16)) $display("FAIL wrap_seq4[%0d] got %0d want %0d", i, o4_out_seq, i % 16); else n_pass++;
      n_checks++; if (out_seq !== 16'(i)) $display("FAIL wrap_seq16[%0d] got %0d want %0d", i, out_seq, i); else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (o4_out_seq !== 4'd1) $display("FAIL wrap_seq4_end got %0d want 1", o4_out_seq); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd0);
    test_reset();
    test_itype();
    test_s_shamt();
    test_back_to_back();
    test_illegal();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_seq_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
